fma_seq_ctrl: RTL

- Sequencer for the vectorized fma pipeline (product stage, then accumulate stage).
- Accepts a job descriptor (length K, bias vector), then streams K val/weight beats into the fma over a valid/ready interface.
- Drives the fma mode and bias, and zero-gates the weight on stalls so idle cycles accumulate 0.
- Presents the finished sum vector on a valid/ready result port.

---
 rtl/fma_pkg.sv | 28 ++
 rtl/fma_operand_gate.sv | 26 ++
 rtl/fma_seq_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fma_pkg.sv
// ---------------------------------------------------------------------------
// fma_pkg
// Shared definitions for the fma sequencer and the fma datapath it drives.
//   - state_t      : sequencer states (IDLE, LOAD, ACCUM, DRAIN, DONE)
//   - DEFAULT_*    : default widths shared with the fma
//   - *_vec_t      : packed lane vectors at the default widths
// ---------------------------------------------------------------------------
package fma_pkg;

   localparam int DEFAULT_DATA_WIDTH   = 8;
   localparam int DEFAULT_WEIGHT_WIDTH = 8;
   localparam int DEFAULT_VECTOR_WIDTH = 4;
   localparam int DEFAULT_OUTPUT_WIDTH = 16;
   localparam int DEFAULT_MAX_LEN      = 256;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ACCUM,
      DRAIN,
      DONE
   } state_t;

   typedef logic [DEFAULT_VECTOR_WIDTH*DEFAULT_DATA_WIDTH-1:0]   val_vec_t;
   typedef logic [DEFAULT_VECTOR_WIDTH*DEFAULT_WEIGHT_WIDTH-1:0] weight_vec_t;
   typedef logic [DEFAULT_VECTOR_WIDTH*DEFAULT_OUTPUT_WIDTH-1:0] sum_vec_t;

endpackage

// File: rtl/fma_operand_gate.sv
// ---------------------------------------------------------------------------
// fma_operand_gate
// Per-lane weight zero-gate. When no beat is accepted, every lane's weight is
// forced to zero so the fma product is 0 and the accumulator holds.
// Ports:
//   accept : beat accepted this cycle
//   weight : incoming weight vector (VECTOR_WIDTH lanes of WEIGHT_WIDTH)
//   gated  : weight when accept, else all zeros
// ---------------------------------------------------------------------------
module fma_operand_gate
   import fma_pkg::*;
#(
   parameter int WEIGHT_WIDTH = DEFAULT_WEIGHT_WIDTH,
   parameter int VECTOR_WIDTH = DEFAULT_VECTOR_WIDTH
) (
   input  logic                                 accept,
   input  logic [VECTOR_WIDTH*WEIGHT_WIDTH-1:0] weight,
   output logic [VECTOR_WIDTH*WEIGHT_WIDTH-1:0] gated
);

   for (genvar lane = 0; lane < VECTOR_WIDTH; lane++) begin : g_lane
      assign gated[lane*WEIGHT_WIDTH +: WEIGHT_WIDTH] =
         accept ? weight[lane*WEIGHT_WIDTH +: WEIGHT_WIDTH] : '0;
   end

endmodule

// File: rtl/fma_seq_ctrl.sv
// ---------------------------------------------------------------------------
// fma_seq_ctrl
// Sequencer for the vectorized fma pipeline (product stage, then accumulate
// stage). Accepts a job (length K, per-lane bias), streams K val/weight beats
// into the fma, then presents the finished sum vector on a valid/ready port.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start_*             : job request handshake, length and per-lane bias
//   in_*                : operand beat handshake, val and weight vectors
//   out_*               : result handshake and sum vector (= fma_sum)
//   busy                : sequencer not idle
//   fma_rstn            : fma reset (= ~rst)
//   fma_mode            : 0 = load bias, 1 = accumulate
//   fma_val/fma_weight  : operands to the fma (weight zeroed when no accept)
//   fma_bias            : registered job bias
//   fma_sum             : fma accumulator output
//   stall_count         : only with FMA_SEQ_PERF_EN defined; input-starved
//                         LOAD/ACCUM cycles of the current job, saturating
//
// Build option: define FMA_SEQ_PERF_EN to add the stall_count output.
// ---------------------------------------------------------------------------
module fma_seq_ctrl
   import fma_pkg::*;
#(
   parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
   parameter int WEIGHT_WIDTH = DEFAULT_WEIGHT_WIDTH,
   parameter int VECTOR_WIDTH = DEFAULT_VECTOR_WIDTH,
   parameter int OUTPUT_WIDTH = DEFAULT_OUTPUT_WIDTH,
   parameter int MAX_LEN      = DEFAULT_MAX_LEN,
   parameter int LEN_WIDTH    = $clog2(MAX_LEN + 1)
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start_valid,
   output logic                                 start_ready,
   input  logic [LEN_WIDTH-1:0]                 start_len,
   input  logic [VECTOR_WIDTH*OUTPUT_WIDTH-1:0] start_bias,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [VECTOR_WIDTH*DATA_WIDTH-1:0]   in_val,
   input  logic [VECTOR_WIDTH*WEIGHT_WIDTH-1:0] in_weight,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [VECTOR_WIDTH*OUTPUT_WIDTH-1:0] out_data,
   output logic                                 busy,
   output logic                                 fma_rstn,
   output logic                                 fma_mode,
   output logic [VECTOR_WIDTH*DATA_WIDTH-1:0]   fma_val,
   output logic [VECTOR_WIDTH*WEIGHT_WIDTH-1:0] fma_weight,
   output logic [VECTOR_WIDTH*OUTPUT_WIDTH-1:0] fma_bias,
   input  logic [VECTOR_WIDTH*OUTPUT_WIDTH-1:0] fma_sum
`ifdef FMA_SEQ_PERF_EN
   ,
   output logic [15:0]                          stall_count
`endif
);

   state_t                              state;
   state_t                              state_next;
   logic [LEN_WIDTH-1:0]                count;
   logic [LEN_WIDTH-1:0]                count_next;
   logic [LEN_WIDTH-1:0]                len_q;
   logic [LEN_WIDTH-1:0]                len_clamped;
   logic [VECTOR_WIDTH*OUTPUT_WIDTH-1:0] bias_q;
   logic                                start_fire;
   logic                                in_fire;

   // Handshake readies depend only on registered state, which keeps the
   // accept signals free of combinational loops through the next-state logic.
   assign start_ready = (state == IDLE);
   assign in_ready    = ((state == LOAD) || (state == ACCUM)) && (count < len_q);
   assign start_fire  = start_valid && start_ready;
   assign in_fire     = in_valid && in_ready;

   // Oversized requests run as a MAX_LEN job rather than overrunning the counter.
   assign len_clamped = (start_len > LEN_WIDTH'(MAX_LEN)) ? LEN_WIDTH'(MAX_LEN) : start_len;

   // Beat count including this cycle's accept; the FSM decides on it so the
   // last accept moves straight into DRAIN on the following cycle.
   assign count_next = in_fire ? count + LEN_WIDTH'(1) : count;

   assign fma_rstn = ~rst;
   assign fma_val  = in_val;
   assign fma_bias = bias_q;
   assign out_data = fma_sum;

   fma_operand_gate #(
      .WEIGHT_WIDTH (WEIGHT_WIDTH),
      .VECTOR_WIDTH (VECTOR_WIDTH)
   ) u_gate (
      .accept (in_fire),
      .weight (in_weight),
      .gated  (fma_weight)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and state-decoded outputs. LOAD is the only cycle that loads
   // the bias; every other state accumulates, relying on the zero-gated
   // weight to hold the sum when nothing is accepted.
   always_comb begin
      state_next = state;
      fma_mode   = 1'b1;
      out_valid  = 1'b0;
      busy       = (state != IDLE);
      unique case (state)
         IDLE: begin
            if (start_fire) state_next = LOAD;
         end
         LOAD: begin
            fma_mode   = 1'b0;
            state_next = (count_next == len_q) ? DRAIN : ACCUM;
         end
         ACCUM: begin
            if (count_next == len_q) state_next = DRAIN;
         end
         DRAIN: begin
            state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Job descriptor and beat counter
   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= '0;
         len_q  <= '0;
         bias_q <= '0;
      end else if (start_fire) begin
         count  <= '0;
         len_q  <= len_clamped;
         bias_q <= start_bias;
      end else begin
         count <= count_next;
      end
   end

`ifdef FMA_SEQ_PERF_EN
   // Input-starved cycles: the sequencer could take a beat but none offered.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_count <= '0;
      end else if (start_fire) begin
         stall_count <= '0;
      end else if (in_ready && !in_valid && (stall_count != 16'hFFFF)) begin
         stall_count <= stall_count + 16'd1;
      end
   end
`endif

endmodule
